// File: rtl/priority_enc8t3_seq_if.sv
// Request/index handshake bundle for priority_enc8t3_seq.
// The request source and the index consumer both sit on the master side.
interface priority_enc8t3_seq_if;
  logic       en;
  logic [7:0] w;
  logic       w_valid;
  logic       w_ready;
  logic [2:0] y;
  logic       y_valid;
  logic       y_ready;
  logic       last;
  logic       zero;

  modport master (
    output en, w, w_valid, y_ready,
    input  w_ready, y, y_valid, last, zero
  );

  modport slave (
    input  en, w, w_valid, y_ready,
    output w_ready, y, y_valid, last, zero
  );
endinterface

// File: rtl/priority_enc8t3_seq.sv
// Sequential 8-to-3 priority encoder: accepts one request vector, then emits
// the index of each set bit, lowest first, one beat per output handshake.
module priority_enc8t3_seq (
  input  logic                  clk,
  input  logic                  rst,
  priority_enc8t3_seq_if.slave  bus
);

  localparam int N    = 8;
  localparam int LOGN = 3;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      pend_q, pend_d;
  logic              zflag_q, zflag_d;

  logic [LOGN-1:0]   low_idx;
  logic [N-1:0]      pend_cleared;
  logic              one_hot;
  logic              last_beat;

  // Downward scan so the final hit is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        low_idx = LOGN'(i);
      end
    end
  end

  assign pend_cleared = pend_q & ~(N'(1) << low_idx);
  assign one_hot      = (pend_q != '0) && (pend_cleared == '0);
  assign last_beat    = zflag_q || one_hot;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zflag_d = zflag_q;
    case (state_q)
      IDLE: begin
        if (bus.w_valid && bus.en) begin
          pend_d  = bus.w;
          zflag_d = (bus.w == '0);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.y_ready) begin
          pend_d = pend_cleared;
          if (last_beat) begin
            pend_d  = '0;
            zflag_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zflag_q <= zflag_d;
    end
  end

  // Reset gates w_ready directly so it drops without waiting for an edge.
  assign bus.w_ready = (state_q == IDLE) && bus.en && !rst;
  assign bus.y_valid = (state_q == EMIT);
  assign bus.y       = (state_q == EMIT) ? low_idx : '0;
  assign bus.last    = (state_q == EMIT) && last_beat;
  assign bus.zero    = (state_q == EMIT) && zflag_q;

endmodule

// File: tb/tb_priority_enc8t3_seq.sv
// Self-checking bench for priority_enc8t3_seq: directed boundary cases plus
// randomized vectors scored against a beat-list reference model.
module tb_priority_enc8t3_seq;

  typedef struct {
    logic [2:0] idx;
    logic       last;
    logic       zero;
  } beat_t;

  logic clk;
  logic rst;

  priority_enc8t3_seq_if bus_if ();

  priority_enc8t3_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  beat_t exp_q[$];
  int    n_vec        = 0;
  int    n_bad        = 0;
  int    cyc          = 0;
  int    accept_count = 0;
  int    accept_edge  = 0;
  int    last_edge    = 0;
  int    beats_seen   = 0;
  int    ready_mode   = 0;
  logic  manual_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: one beat per set bit in ascending order, or a single zero beat.
  function automatic void push_model(input logic [7:0] v);
    beat_t b;
    int    top;
    if (v == 8'h00) begin
      b.idx = 3'd0; b.last = 1'b1; b.zero = 1'b1;
      exp_q.push_back(b);
    end else begin
      top = 0;
      for (int i = 0; i < 8; i++) if (v[i]) top = i;
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          b.idx = 3'(i); b.last = (i == top); b.zero = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endfunction

  function automatic int beat_count(input logic [7:0] v);
    int k = 0;
    for (int i = 0; i < 8; i++) if (v[i]) k++;
    return (k == 0) ? 1 : k;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0)      bus_if.y_ready = 1'b1;
    else if (ready_mode == 1) bus_if.y_ready = 1'($urandom_range(0, 1));
    else                      bus_if.y_ready = manual_ready;
  end

  // Monitor: every cycle, outputs must match the model's pending beat list.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      checkOutput("y_valid", 32'(bus_if.y_valid), 32'(exp_q.size() != 0));
      checkOutput("w_ready", 32'(bus_if.w_ready), 32'((exp_q.size() == 0) && bus_if.en));
      if (exp_q.size() != 0) begin
        checkOutput("y",    32'(bus_if.y),    32'(exp_q[0].idx));
        checkOutput("last", 32'(bus_if.last), 32'(exp_q[0].last));
        checkOutput("zero", 32'(bus_if.zero), 32'(exp_q[0].zero));
        if (bus_if.y_ready) begin
          if (exp_q[0].last) last_edge = cyc + 1;
          void'(exp_q.pop_front());
          beats_seen = beats_seen + 1;
        end
      end else if (bus_if.w_valid && bus_if.en) begin
        push_model(bus_if.w);
        accept_edge  = cyc + 1;
        accept_count = accept_count + 1;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] v, input bit keep_valid);
    int start = accept_count;
    bus_if.w       = v;
    bus_if.w_valid = 1'b1;
    for (int t = 0; t < 200 && accept_count == start; t++) @(posedge clk);
    #1;
    checkOutput("accepted", 32'(accept_count - start), 32'd1);
    if (!keep_valid) bus_if.w_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_full_rate(input logic [7:0] v);
    applyStimulus(v, 1'b0);
    drain();
    checkOutput("latency", 32'(last_edge - accept_edge), 32'(beat_count(v)));
  endtask

  initial begin
    int   start_beats;
    int   start_acc;
    int   first_edge;
    logic [7:0] v;

    rst            = 1'b1;
    bus_if.en      = 1'b0;
    bus_if.w       = 8'h00;
    bus_if.w_valid = 1'b0;
    bus_if.y_ready = 1'b0;

    #1;
    checkOutput("rst_y_valid", 32'(bus_if.y_valid), 32'd0);
    checkOutput("rst_w_ready", 32'(bus_if.w_ready), 32'd0);
    checkOutput("rst_y",       32'(bus_if.y),       32'd0);
    checkOutput("rst_last",    32'(bus_if.last),    32'd0);
    checkOutput("rst_zero",    32'(bus_if.zero),    32'd0);

    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    bus_if.en = 1'b1;
    #1;
    checkOutput("post_rst_w_ready", 32'(bus_if.w_ready), 32'd1);

    ready_mode = 0;
    run_full_rate(8'b1010_0110);
    run_full_rate(8'h00);
    run_full_rate(8'h80);
    run_full_rate(8'hFF);

    ready_mode   = 2;
    manual_ready = 1'b0;
    start_beats  = beats_seen;
    applyStimulus(8'b0001_0001, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      manual_ready = ~manual_ready;
      @(posedge clk);
      #1;
    end
    drain();
    checkOutput("stall_beats", 32'(beats_seen - start_beats), 32'd2);
    ready_mode = 0;

    start_acc      = accept_count;
    bus_if.en      = 1'b0;
    bus_if.w       = 8'h55;
    bus_if.w_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("en_gate_no_accept", 32'(accept_count - start_acc), 32'd0);
    bus_if.w_valid = 1'b0;
    bus_if.en      = 1'b1;
    @(posedge clk);
    #1;

    start_beats = beats_seen;
    applyStimulus(8'h0C, 1'b0);
    bus_if.en = 1'b0;
    drain();
    checkOutput("en_drop_beats", 32'(beats_seen - start_beats), 32'd2);
    bus_if.en = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(8'h03, 1'b1);
    first_edge = accept_edge;
    applyStimulus(8'h40, 1'b0);
    drain();
    checkOutput("b2b_cycles", 32'(last_edge - first_edge), 32'd4);

    applyStimulus(8'hF0, 1'b0);
    @(posedge clk);
    #1;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_y_valid", 32'(bus_if.y_valid), 32'd0);
    checkOutput("mid_rst_w_ready", 32'(bus_if.w_ready), 32'd0);
    checkOutput("mid_rst_y",       32'(bus_if.y),       32'd0);
    checkOutput("mid_rst_last",    32'(bus_if.last),    32'd0);
    checkOutput("mid_rst_zero",    32'(bus_if.zero),    32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_release_w_ready", 32'(bus_if.w_ready), 32'd1);
    @(posedge clk);
    #1;

    ready_mode = 1;
    for (int n = 0; n < 150; n++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 9) == 0) v = 8'h00;
      applyStimulus(v, 1'($urandom_range(0, 1)));
    end
    bus_if.w_valid = 1'b0;
    ready_mode     = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
